// File: rtl/mem_access_stage.sv
// MEM stage: drives the req/ack data-memory port, resolves pcsrc, registers MEM/WB,
// stalls upstream while an access waits and aborts misaligned or timed-out accesses.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        startin_n,
  input  logic        jump,
  input  logic        branch,
  input  logic        memread,
  input  logic        memtoreg,
  input  logic        memwrite,
  input  logic        regwrite,
  input  logic        zero,
  input  logic [31:0] aluResult,
  input  logic [31:0] read2,
  input  logic [4:0]  regDstMux,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        pcsrc,
  output logic        regwrite_wb,
  output logic        memtoreg_wb,
  output logic [31:0] readData_wb,
  output logic [31:0] aluResult_wb,
  output logic [4:0]  regDst_wb,
  output logic        mem_err,
  output logic [1:0]  err_code,
  output logic        dbg_state
);

  typedef enum logic {
    S_IDLE = 1'b0,
    S_WAIT = 1'b1
  } state_t;

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  state_t      state_q, state_d;
  logic [7:0]  cnt_q, cnt_d;
  logic        memop, aligned, misaligned, timeout_hit, bubble, rd_done;

  logic        regwrite_q, regwrite_d;
  logic        memtoreg_q, memtoreg_d;
  logic [31:0] rdata_q, rdata_d;
  logic [31:0] alu_q, alu_d;
  logic [4:0]  rd_q, rd_d;
  logic        err_q, err_d;
  logic [1:0]  code_q, code_d;

  assign memop      = memread | memwrite;
  assign aligned    = (aluResult[1:0] == 2'b00);
  assign misaligned = (state_q == S_IDLE) & memop & ~aligned;

  // Handshake: a transfer completes in any cycle with dmem_req=1 and dmem_ack=1;
  // once raised, dmem_req stays high with stable addr/wdata/we until ack or timeout.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dmem_req    = 1'b0;
    timeout_hit = 1'b0;
    case (state_q)
      S_IDLE: begin
        dmem_req = startin_n & memop & aligned;
        if (dmem_req & ~dmem_ack) begin
          state_d = S_WAIT;
          cnt_d   = 8'd0;
        end
      end
      S_WAIT: begin
        dmem_req    = 1'b1;
        timeout_hit = (cnt_q == CNT_LAST) & ~dmem_ack;
        if (dmem_ack | timeout_hit) begin
          state_d = S_IDLE;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign stall   = dmem_req & ~dmem_ack & ~timeout_hit;
  assign bubble  = stall | misaligned | timeout_hit;
  assign rd_done = dmem_req & dmem_ack & ~memwrite;

  always_comb begin
    regwrite_d = regwrite_q;
    memtoreg_d = memtoreg_q;
    rdata_d    = rdata_q;
    alu_d      = alu_q;
    rd_d       = rd_q;
    err_d      = err_q;
    code_d     = code_q;
    if (bubble) begin
      regwrite_d = 1'b0;
      memtoreg_d = 1'b0;
    end else begin
      regwrite_d = regwrite;
      memtoreg_d = memtoreg;
      alu_d      = aluResult;
      rd_d       = regDstMux;
      if (rd_done) begin
        rdata_d = dmem_rdata;
      end
    end
    // Only the first error is recorded; later aborts leave the code untouched.
    if ((misaligned | timeout_hit) & ~err_q) begin
      err_d  = 1'b1;
      code_d = misaligned ? 2'b01 : 2'b10;
    end
  end

  always_ff @(posedge clk or negedge startin_n) begin
    if (!startin_n) begin
      state_q    <= S_IDLE;
      cnt_q      <= 8'd0;
      regwrite_q <= 1'b0;
      memtoreg_q <= 1'b0;
      rdata_q    <= 32'd0;
      alu_q      <= 32'd0;
      rd_q       <= 5'd0;
      err_q      <= 1'b0;
      code_q     <= 2'b00;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      regwrite_q <= regwrite_d;
      memtoreg_q <= memtoreg_d;
      rdata_q    <= rdata_d;
      alu_q      <= alu_d;
      rd_q       <= rd_d;
      err_q      <= err_d;
      code_q     <= code_d;
    end
  end

  assign dmem_we      = memwrite;
  assign dmem_addr    = aluResult;
  assign dmem_wdata   = read2;
  assign pcsrc        = (branch & zero) | jump;
  assign regwrite_wb  = regwrite_q;
  assign memtoreg_wb  = memtoreg_q;
  assign readData_wb  = rdata_q;
  assign aluResult_wb = alu_q;
  assign regDst_wb    = rd_q;
  assign mem_err      = err_q;
  assign err_code     = code_q;
  assign dbg_state    = state_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: expected MEM/WB words are queued when an
// instruction is driven and compared at the edge where the instruction leaves MEM.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        startin_n;
  logic        jump, branch, memread, memtoreg, memwrite, regwrite, zero;
  logic [31:0] aluResult, read2, dmem_addr, dmem_wdata, dmem_rdata;
  logic [4:0]  regDstMux, regDst_wb;
  logic        dmem_req, dmem_we, dmem_ack, stall, pcsrc;
  logic        regwrite_wb, memtoreg_wb, mem_err, dbg_state;
  logic [31:0] readData_wb, aluResult_wb;
  logic [1:0]  err_code;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .startin_n(startin_n), .jump(jump), .branch(branch),
    .memread(memread), .memtoreg(memtoreg), .memwrite(memwrite),
    .regwrite(regwrite), .zero(zero), .aluResult(aluResult), .read2(read2),
    .regDstMux(regDstMux), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack),
    .dmem_rdata(dmem_rdata), .stall(stall), .pcsrc(pcsrc),
    .regwrite_wb(regwrite_wb), .memtoreg_wb(memtoreg_wb),
    .readData_wb(readData_wb), .aluResult_wb(aluResult_wb),
    .regDst_wb(regDst_wb), .mem_err(mem_err), .err_code(err_code),
    .dbg_state(dbg_state)
  );

  // Clock/reset block
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  logic [70:0] exp_q[$];
  logic [31:0] m_alu, m_rdata;
  logic [4:0]  m_rd;
  logic        m_err;
  logic [1:0]  m_code;

  task automatic check_eq(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [70:0] wb_now();
    return {regwrite_wb, memtoreg_wb, readData_wb, aluResult_wb, regDst_wb};
  endfunction

  task automatic clear_inputs();
    jump = 0; branch = 0; memread = 0; memtoreg = 0; memwrite = 0; regwrite = 0;
    zero = 0; aluResult = 0; read2 = 0; regDstMux = 0; dmem_ack = 0; dmem_rdata = 0;
  endtask

  // Asserts reset with busy, nonzero inputs; returns at posedge+1 with reset released.
  task automatic reset_dut();
    jump = 1; branch = 1; memread = 1; memtoreg = 1; memwrite = 0; regwrite = 1;
    zero = 1; aluResult = 32'h100; read2 = 32'hFFFF; regDstMux = 5'h1f;
    dmem_ack = 1; dmem_rdata = 32'hA5A5A5A5;
    startin_n = 0;
    #1;
    check_eq("rst_req", 128'(dmem_req), 128'(0));
    check_eq("rst_stall", 128'(stall), 128'(0));
    check_eq("rst_wb", 128'(wb_now()), 128'(0));
    check_eq("rst_err", 128'({mem_err, err_code}), 128'(0));
    check_eq("rst_state", 128'(dbg_state), 128'(0));
    clear_inputs();
    @(posedge clk); #1;
    startin_n = 1;
    m_alu = 0; m_rdata = 0; m_rd = 0; m_err = 0; m_code = 2'b00;
    exp_q.delete();
  endtask

  // Driver: delay = cycles from first request to ack; negative means never ack.
  task automatic run_instr(input logic j, input logic b, input logic mr, input logic mt,
                           input logic mw, input logic rw, input logic z,
                           input logic [31:0] alu, input logic [31:0] r2,
                           input logic [4:0] rd, input int delay, input logic [31:0] rdata);
    logic        ok, mis, to;
    int          ncyc;
    logic [70:0] exp, got;
    ok   = (mr | mw) & (alu[1:0] == 2'b00);
    mis  = (mr | mw) & (alu[1:0] != 2'b00);
    to   = ok && (delay < 0);
    ncyc = !ok ? 1 : (delay < 0 ? TO + 1 : delay + 1);
    jump = j; branch = b; memread = mr; memtoreg = mt; memwrite = mw; regwrite = rw;
    zero = z; aluResult = alu; read2 = r2; regDstMux = rd;
    if (mis || to) begin
      exp = {2'b00, m_rdata, m_alu, m_rd};
      if (!m_err) begin
        m_err  = 1;
        m_code = mis ? 2'b01 : 2'b10;
      end
    end else begin
      if (ok && mr && !mw) m_rdata = rdata;
      m_alu = alu;
      m_rd  = rd;
      exp   = {rw, mt, m_rdata, m_alu, m_rd};
    end
    exp_q.push_back(exp);
    for (int i = 0; i < ncyc; i++) begin
      if (ok) begin
        dmem_ack   = (i == delay);
        dmem_rdata = (i == delay) ? rdata : $urandom;
      end else begin
        dmem_ack   = 1'($urandom_range(0, 1));
        dmem_rdata = $urandom;
      end
      @(negedge clk);
      check_eq("req", 128'(dmem_req), 128'(ok));
      check_eq("stall", 128'(stall), 128'(ok && (i < ncyc - 1)));
      if (ok) begin
        check_eq("we", 128'(dmem_we), 128'(mw));
        check_eq("addr", 128'(dmem_addr), 128'(alu));
        check_eq("wdata", 128'(dmem_wdata), 128'(r2));
      end
      if (i == 0) check_eq("pcsrc", 128'(pcsrc), 128'((b & z) | j));
      @(posedge clk); #1;
    end
    got = wb_now();
    if (exp_q.size() == 0) begin
      check_eq("queue_underflow", 128'(1), 128'(0));
    end else begin
      exp = exp_q.pop_front();
      check_eq("memwb", 128'(got), 128'(exp));
    end
    check_eq("mem_err", 128'(mem_err), 128'(m_err));
    check_eq("err_code", 128'(err_code), 128'(m_code));
    check_eq("state_idle", 128'(dbg_state), 128'(0));
    dmem_ack = 0;
  endtask

  initial begin
    clear_inputs();
    startin_n = 0;
    reset_dut();

    // timeout on a fresh error flag
    run_instr(0, 0, 1, 1, 0, 1, 0, 32'h200, 32'h0, 5'd7, -1, 32'h0);
    check_eq("to_code", 128'(err_code), 128'(2'b10));

    reset_dut();
    // plain ALU op, zero-wait load, waited store
    run_instr(0, 0, 0, 0, 0, 1, 0, 32'h55, 32'h9, 5'd3, 0, 32'h0);
    run_instr(0, 0, 1, 1, 0, 1, 0, 32'h100, 32'h0, 5'd5, 0, 32'hDEADBEEF);
    check_eq("load_data", 128'(readData_wb), 128'(32'hDEADBEEF));
    run_instr(0, 0, 0, 0, 1, 0, 0, 32'h40, 32'h1234, 5'd2, 3, 32'h0);
    check_eq("store_rw", 128'(regwrite_wb), 128'(0));
    // branch / jump
    run_instr(0, 1, 0, 0, 0, 0, 1, 32'h8, 32'h0, 5'd0, 0, 32'h0);
    run_instr(0, 1, 0, 0, 0, 0, 0, 32'h8, 32'h0, 5'd0, 0, 32'h0);
    run_instr(1, 0, 0, 0, 0, 0, 0, 32'h8, 32'h0, 5'd0, 0, 32'h0);
    // misaligned, then a timeout that must not overwrite the code
    run_instr(0, 0, 1, 1, 0, 1, 0, 32'h102, 32'h0, 5'd9, 0, 32'h0);
    check_eq("mis_code", 128'(err_code), 128'(2'b01));
    run_instr(0, 0, 1, 1, 0, 1, 0, 32'h300, 32'h0, 5'd4, -1, 32'h0);
    check_eq("mis_sticky", 128'(err_code), 128'(2'b01));

    // random back-to-back traffic
    for (int n = 0; n < 40; n++) begin
      int          kind;
      logic [31:0] a;
      kind = $urandom_range(0, 3);
      a    = $urandom & 32'hFFFF_FFFC;
      run_instr(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                kind == 1 || kind == 3, 1'($urandom_range(0, 1)),
                kind == 2 || kind == 3, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), a, $urandom, 5'($urandom_range(0, 31)),
                $urandom_range(0, 3), $urandom);
    end

    // reset while waiting for an ack
    memread = 1; memtoreg = 1; regwrite = 1; aluResult = 32'h80; regDstMux = 5'd6;
    dmem_ack = 0;
    @(posedge clk); #1;
    check_eq("wait_state", 128'(dbg_state), 128'(1));
    @(posedge clk); #1;
    reset_dut();
    run_instr(0, 0, 1, 1, 0, 1, 0, 32'h84, 32'h0, 5'd6, 1, 32'h600D600D);

    check_eq("queue_empty", 128'(exp_q.size()), 128'(0));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not reach the end");
    $fatal(1, "watchdog");
  end

endmodule
